// File: rtl/ax_split_4kb_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : ax_split_4kb_ctrl_pkg
//  Description : Shared interconnect definitions for the 4KB burst splitter:
//                page offset width, page size constant and FSM encoding.
//  Revision    : 1.0  initial release
// ============================================================================
package ax_split_4kb_ctrl_pkg;

   // Number of address bits that address bytes within one 4KB page
   localparam int c_PAGE_OFS_W = 12;

   // Page size expressed on c_PAGE_OFS_W+1 bits (0x1000)
   localparam logic [c_PAGE_OFS_W:0] c_PAGE_BYTES = {1'b1, {c_PAGE_OFS_W{1'b0}}};

   // Splitter control states
   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_SEND_1ST = 2'd1,
      ST_SEND_2ND = 2'd2
   } split_state_e;

endpackage : ax_split_4kb_ctrl_pkg
`default_nettype wire

// File: rtl/ax_split_4kb_ctrl_masker.sv
`default_nettype none
// ============================================================================
//  Module      : splitting_4kb_masker
//  Description : Combinational address/length computation for a burst that
//                may straddle a 4KB page. mask_sel_i=0 yields the first part,
//                mask_sel_i=1 yields the remainder starting on the next page.
//                Start addresses are assumed aligned to the beat size.
//  Revision    : 1.0  initial release
// ============================================================================
module splitting_4kb_masker
   import ax_split_4kb_ctrl_pkg::*;
#(
   parameter int ADDR_WIDTH = 32,
   parameter int LEN_WIDTH  = 3,
   parameter int SIZE_WIDTH = 3
) (
   input  logic [ADDR_WIDTH-1:0] i_addr,
   input  logic [LEN_WIDTH-1:0]  i_len,
   input  logic [SIZE_WIDTH-1:0] i_size,
   input  logic                  mask_sel_i,
   output logic [ADDR_WIDTH-1:0] o_addr,
   output logic [LEN_WIDTH-1:0]  o_len,
   output logic                  o_split
);

   // One extra bit so that an end address of exactly 0x1000 is representable
   localparam int c_CW = c_PAGE_OFS_W + 1;

   logic [c_CW-1:0]       w_ofs;
   logic [c_CW-1:0]       w_beats;
   logic [c_CW-1:0]       w_bytes;
   logic [c_CW-1:0]       w_end;
   logic [c_CW-1:0]       w_room;
   logic [c_CW-1:0]       w_beats1;
   logic [ADDR_WIDTH-1:0] w_next_page;
   logic                  w_split;

   assign w_ofs    = {1'b0, i_addr[c_PAGE_OFS_W-1:0]};
   assign w_beats  = c_CW'(i_len) + c_CW'(1);
   assign w_bytes  = w_beats << i_size;
   assign w_end    = w_ofs + w_bytes;
   // Ending exactly on the page boundary stays in one page
   assign w_split  = (w_end > c_PAGE_BYTES);
   // Bytes left in the current page, and how many whole beats fit there
   assign w_room   = c_PAGE_BYTES - w_ofs;
   assign w_beats1 = w_room >> i_size;
   // Setting the offset bits then adding one lands on the next 4KB boundary
   assign w_next_page = (i_addr | ADDR_WIDTH'({c_PAGE_OFS_W{1'b1}})) + ADDR_WIDTH'(1);

   assign o_split = w_split;

   // Select first-part or second-part address and length
   always_comb begin
      o_addr = i_addr;
      o_len  = i_len;
      if (mask_sel_i) begin
         o_addr = w_next_page;
         o_len  = LEN_WIDTH'(c_CW'(i_len) - w_beats1);
      end else if (w_split) begin
         o_len  = LEN_WIDTH'(w_beats1 - c_CW'(1));
      end
   end

endmodule : splitting_4kb_masker
`default_nettype wire

// File: rtl/ax_split_4kb_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : ax_split_4kb_ctrl
//  Description : AXI address-channel splitter. Registers one upstream
//                request and issues it downstream as one sub-transaction,
//                or as two when the burst crosses a 4KB page boundary.
//  Revision    : 1.0  initial release
// ============================================================================
module ax_split_4kb_ctrl
   import ax_split_4kb_ctrl_pkg::*;
#(
   parameter int ADDR_WIDTH = 32,
   parameter int LEN_WIDTH  = 3,
   parameter int SIZE_WIDTH = 3,
   parameter int ID_WIDTH   = 5
) (
   input  logic                  ACLK_i,
   input  logic                  ARESET_i,
   input  logic [ID_WIDTH-1:0]   s_AxID_i,
   input  logic [ADDR_WIDTH-1:0] s_AxADDR_i,
   input  logic [LEN_WIDTH-1:0]  s_AxLEN_i,
   input  logic [SIZE_WIDTH-1:0] s_AxSIZE_i,
   input  logic                  s_AxVALID_i,
   output logic                  s_AxREADY_o,
   output logic [ID_WIDTH-1:0]   m_AxID_o,
   output logic [ADDR_WIDTH-1:0] m_AxADDR_o,
   output logic [LEN_WIDTH-1:0]  m_AxLEN_o,
   output logic [SIZE_WIDTH-1:0] m_AxSIZE_o,
   output logic                  m_AxVALID_o,
   input  logic                  m_AxREADY_i,
   output logic                  m_split_o,
   output logic                  m_last_o,
   output logic [15:0]           split_cnt_o
);

   split_state_e r_state;
   split_state_e w_state_nxt;

   logic [ID_WIDTH-1:0]   r_id;
   logic [ADDR_WIDTH-1:0] r_addr;
   logic [LEN_WIDTH-1:0]  r_len;
   logic [SIZE_WIDTH-1:0] r_size;
   logic [15:0]           r_split_cnt;

   logic                  w_split;
   logic                  w_m_hs;
   logic                  w_final_hs;
   logic                  w_accept;
   logic                  w_mask_sel;

   // Handshakes: the request slot frees up on the last sub-transaction,
   // so a new request can be taken in that same cycle
   assign w_m_hs      = m_AxVALID_o & m_AxREADY_i;
   assign w_final_hs  = w_m_hs & (((r_state == ST_SEND_1ST) & ~w_split) |
                                  (r_state == ST_SEND_2ND));
   assign s_AxREADY_o = (r_state == ST_IDLE) | w_final_hs;
   assign w_accept    = s_AxVALID_i & s_AxREADY_o;
   assign w_mask_sel  = (r_state == ST_SEND_2ND);

   splitting_4kb_masker #(
      .ADDR_WIDTH (ADDR_WIDTH),
      .LEN_WIDTH  (LEN_WIDTH),
      .SIZE_WIDTH (SIZE_WIDTH)
   ) u_masker (
      .i_addr     (r_addr),
      .i_len      (r_len),
      .i_size     (r_size),
      .mask_sel_i (w_mask_sel),
      .o_addr     (m_AxADDR_o),
      .o_len      (m_AxLEN_o),
      .o_split    (w_split)
   );

   assign m_AxID_o    = r_id;
   assign m_AxSIZE_o  = r_size;
   assign split_cnt_o = r_split_cnt;

   // State register
   always_ff @(posedge ACLK_i or posedge ARESET_i) begin
      if (ARESET_i) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Next-state and downstream control outputs
   always_comb begin
      w_state_nxt = r_state;
      m_AxVALID_o = 1'b0;
      m_split_o   = 1'b0;
      m_last_o    = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (w_accept) begin
               w_state_nxt = ST_SEND_1ST;
            end
         end
         ST_SEND_1ST: begin
            m_AxVALID_o = 1'b1;
            m_split_o   = w_split;
            m_last_o    = ~w_split;
            if (w_m_hs) begin
               if (w_split) begin
                  w_state_nxt = ST_SEND_2ND;
               end else if (w_accept) begin
                  w_state_nxt = ST_SEND_1ST;
               end else begin
                  w_state_nxt = ST_IDLE;
               end
            end
         end
         ST_SEND_2ND: begin
            m_AxVALID_o = 1'b1;
            m_split_o   = 1'b1;
            m_last_o    = 1'b1;
            if (w_m_hs) begin
               w_state_nxt = w_accept ? ST_SEND_1ST : ST_IDLE;
            end
         end
         default: begin
            w_state_nxt = ST_IDLE;
         end
      endcase
   end

   // Capture the upstream request; fields stay frozen until the next accept
   always_ff @(posedge ACLK_i or posedge ARESET_i) begin
      if (ARESET_i) begin
         r_id   <= '0;
         r_addr <= '0;
         r_len  <= '0;
         r_size <= '0;
      end else if (w_accept) begin
         r_id   <= s_AxID_i;
         r_addr <= s_AxADDR_i;
         r_len  <= s_AxLEN_i;
         r_size <= s_AxSIZE_i;
      end
   end

   // Count split requests when their first half is handed off, saturating
   always_ff @(posedge ACLK_i or posedge ARESET_i) begin
      if (ARESET_i) begin
         r_split_cnt <= '0;
      end else if (w_m_hs && (r_state == ST_SEND_1ST) && w_split &&
                   (r_split_cnt != 16'hFFFF)) begin
         r_split_cnt <= r_split_cnt + 16'd1;
      end
   end

endmodule : ax_split_4kb_ctrl
`default_nettype wire

// File: doc/ax_split_4kb_ctrl.md
AX_SPLIT_4KB_CTRL -- requirements
Module: ax_split_4kb_ctrl

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 32, address width.
REQ-002 SHALL have parameter LEN_WIDTH, default 3, burst-length field width.
REQ-003 SHALL have parameter SIZE_WIDTH, default 3, burst-size field width; LEN_WIDTH+2**SIZE_WIDTH <= 12 is required.
REQ-004 SHALL have parameter ID_WIDTH, default 5, transaction ID width.
REQ-005 SHALL have port ACLK_i, input, 1, the only clock; all state changes on its rising edge.
REQ-006 SHALL have port ARESET_i, input, 1, asynchronous active-high reset.
REQ-007 SHALL have ports s_AxID_i/s_AxADDR_i/s_AxLEN_i/s_AxSIZE_i, input, ID/ADDR/LEN/SIZE widths, upstream address request.
REQ-008 SHALL have ports s_AxVALID_i (input, 1) and s_AxREADY_o (output, 1), upstream handshake.
REQ-009 SHALL have ports m_AxID_o/m_AxADDR_o/m_AxLEN_o, output, ID/ADDR/LEN widths, and m_AxSIZE_o (output, SIZE_WIDTH); downstream sub-transaction.
REQ-010 SHALL have ports m_AxVALID_o (output, 1) and m_AxREADY_i (input, 1), downstream handshake.
REQ-011 SHALL have port m_split_o, output, 1, high when the current sub-transaction belongs to a split pair.
REQ-012 SHALL have port m_last_o, output, 1, high on the final sub-transaction of a request.
REQ-013 SHALL have port split_cnt_o, output, 16, saturating count of split requests.

Function
REQ-014 SHALL implement states IDLE, SEND_1ST, SEND_2ND.
REQ-015 SHALL drive s_AxREADY_o = (state==IDLE) OR (final sub-transaction handshake in this cycle).
REQ-016 SHALL, on s_AxVALID_i&s_AxREADY_o, register ID/ADDR/LEN/SIZE and enter SEND_1ST next cycle.
REQ-017 SHALL compute split = (ADDR[11:0] + ((LEN+1)<<SIZE)) > 0x1000, using 13-bit arithmetic; an end exactly on 0x1000 SHALL NOT split.
REQ-018 SHALL, in SEND_1ST, drive m_AxVALID_o=1 with ADDR=registered ADDR and LEN = split ? (beats up to boundary)-1 : registered LEN.
REQ-019 SHALL, in SEND_2ND, drive m_AxVALID_o=1 with ADDR = next 4KB-aligned address and LEN = remaining beats-1.
REQ-020 SHALL pass registered ID and SIZE unchanged on both sub-transactions.
REQ-021 SHALL drive m_split_o=split and m_last_o=!split in SEND_1ST; m_split_o=1 and m_last_o=1 in SEND_2ND.
REQ-022 SHALL hold all m_Ax* outputs stable while m_AxVALID_o=1 and m_AxREADY_i=0.
REQ-023 SHALL transition SEND_1ST->SEND_2ND on handshake if split; otherwise SEND_1ST->IDLE, or SEND_1ST->SEND_1ST if a new request is accepted in the same cycle.
REQ-024 SHALL transition SEND_2ND->IDLE on handshake, or SEND_2ND->SEND_1ST if a new request is accepted in the same cycle.
REQ-025 SHALL give one-cycle latency from upstream acceptance to m_AxVALID_o assertion; no combinational path from s_AxVALID_i to m_AxVALID_o.
REQ-026 SHALL increment split_cnt_o once per accepted split request at its SEND_1ST handshake, saturating at 0xFFFF.
REQ-027 SHALL sustain one unsplit request per cycle under continuous m_AxREADY_i=1.

Reset
REQ-028 SHALL, on ARESET_i assertion at any time including mid-pair, force state IDLE, m_AxVALID_o=0, m_split_o=0, m_last_o=0, split_cnt_o=0, and discard any pending second half.
REQ-029 SHALL reset the registered request fields to 0 and assert s_AxREADY_o=1 during reset.

Structure
REQ-030 SHALL place the 4KB offset constant (12) and the state encoding in the shared interconnect package.
REQ-031 SHALL instantiate one splitting_4kb_masker sub-module with mask_sel_i = (state==SEND_2ND) for the address/length computation.

Verification
REQ-032 SHALL cover: ADDR=0x0FF8, SIZE=2, LEN=3 -> two sub-transactions: (0x0FF8, LEN 1, split=1, last=0), then (0x1000, LEN 1, split=1, last=1); split_cnt_o=1.
REQ-033 SHALL cover: ADDR=0x0100, SIZE=2, LEN=3 -> one sub-transaction (0x0100, LEN 3, split=0, last=1); split_cnt_o unchanged.
REQ-034 SHALL cover: ADDR=0x0FF0, SIZE=2, LEN=3 (ends exactly at 0x1000) -> one sub-transaction (0x0FF0, LEN 3, split=0).
REQ-035 SHALL cover: m_AxREADY_i held low for 5 cycles during SEND_2ND -> outputs stable and s_AxREADY_o=0 until the handshake.
REQ-036 SHALL cover: back-to-back unsplit requests with m_AxREADY_i=1 -> one sub-transaction per cycle with no bubbles.
REQ-037 SHALL cover: ARESET_i pulsed while in SEND_2ND -> next cycle m_AxVALID_o=0, state IDLE, split_cnt_o=0.
